// File: rtl/led_fade_pkg.sv
// Shared types and constants for the LED breathing-fade sequencer.
// Optional gamma table is compiled in only when LED_FADE_GAMMA_EN is defined.
package led_fade_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    UP      = 3'd1,
    HOLD_HI = 3'd2,
    DOWN    = 3'd3,
    HOLD_LO = 3'd4
  } fade_state_t;

  localparam int         PWM_PERIOD = 16;
  localparam logic [3:0] PHASE_UPD  = 4'd14;

`ifdef LED_FADE_GAMMA_EN
  // Packed with level 0 in the low nibble: 0,1,1,1,2,2,3,3,4,5,6,7,9,11,13,15
  localparam logic [63:0] GAMMA_TBL = {4'd15, 4'd13, 4'd11, 4'd9, 4'd7, 4'd6, 4'd5, 4'd4,
                                       4'd3,  4'd3,  4'd2,  4'd2, 4'd1, 4'd1, 4'd1, 4'd0};

  function automatic logic [3:0] gamma(input logic [3:0] lvl);
    return GAMMA_TBL[{2'b00, lvl} * 6'd4 +: 4];
  endfunction
`endif

endpackage

// File: rtl/fade_tick_gen.sv
// Mirrors the dimmer's 16-cycle PWM phase and divides periods into level steps.
// step_tick is combinational: phase==14 on the last period of a step.
module fade_tick_gen
  import led_fade_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] step_div,
  output logic [3:0]       phase,
  output logic             step_tick
);

  logic [DIV_W-1:0] div;

  assign step_tick = (phase == PHASE_UPD) && (div == step_div);

  // Divider advances once per period, at the same phase the duty is allowed to change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase <= '0;
      div   <= '0;
    end else if (!run) begin
      phase <= '0;
      div   <= '0;
    end else begin
      phase <= phase + 4'd1;
      if (phase == PHASE_UPD) begin
        div <= step_tick ? '0 : div + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/led_fade_ctrl.sv
// Breathing-fade sequencer driving a 4-bit PWM dimmer's en/w, duty changes on period boundaries.
// Define LED_FADE_GAMMA_EN to map level through the perceptual gamma table instead of linear.
module led_fade_ctrl
  import led_fade_pkg::*;
#(
  parameter int DIV_W  = 8,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  step_div,
  input  logic [HOLD_W-1:0] hold_hi,
  input  logic [HOLD_W-1:0] hold_lo,
  input  logic [3:0]        max_level,
  input  logic              loop,
  output logic              dim_en,
  output logic [3:0]        dim_w,
  output logic              busy,
  output logic              done
);

  fade_state_t       state, state_nxt;
  logic [3:0]        level, level_nxt;
  logic [HOLD_W-1:0] hold_cnt, hold_nxt;
  logic              en_nxt, done_nxt, cap;

  logic [DIV_W-1:0]  cfg_div;
  logic [HOLD_W-1:0] cfg_hold_hi, cfg_hold_lo;
  logic [3:0]        cfg_max;
  logic              cfg_loop;

  logic [3:0]        phase;
  logic              step_tick;
  logic [3:0]        w_nxt;

  // Run drops on the same edge dim_en falls, so the tick counters clear with everything else.
  fade_tick_gen #(.DIV_W(DIV_W)) u_tick (
    .clk       (clk),
    .rst       (rst),
    .run       (dim_en & en_nxt),
    .step_div  (cfg_div),
    .phase     (phase),
    .step_tick (step_tick)
  );

  always_comb begin
    state_nxt = state;
    level_nxt = level;
    hold_nxt  = hold_cnt;
    en_nxt    = dim_en;
    done_nxt  = 1'b0;
    cap       = 1'b0;
    if (stop) begin
      state_nxt = IDLE;
      level_nxt = '0;
      hold_nxt  = '0;
      en_nxt    = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nxt = UP;
            level_nxt = '0;
            hold_nxt  = '0;
            en_nxt    = 1'b1;
            cap       = 1'b1;
          end
        end
        UP: begin
          if (step_tick) begin
            if (level >= cfg_max) begin
              state_nxt = HOLD_HI;
              hold_nxt  = '0;
            end else begin
              level_nxt = level + 4'd1;
            end
          end
        end
        HOLD_HI: begin
          if (step_tick) begin
            if (hold_cnt == cfg_hold_hi) state_nxt = DOWN;
            else                         hold_nxt  = hold_cnt + HOLD_W'(1);
          end
        end
        DOWN: begin
          if (step_tick) begin
            if (level == 4'd0) begin
              state_nxt = HOLD_LO;
              hold_nxt  = '0;
            end else begin
              level_nxt = level - 4'd1;
            end
          end
        end
        HOLD_LO: begin
          if (step_tick) begin
            if (hold_cnt == cfg_hold_lo) begin
              hold_nxt = '0;
              if (cfg_loop) begin
                state_nxt = UP;
              end else begin
                state_nxt = IDLE;
                en_nxt    = 1'b0;
                done_nxt  = 1'b1;
              end
            end else begin
              hold_nxt = hold_cnt + HOLD_W'(1);
            end
          end
        end
        default: begin
          state_nxt = IDLE;
          level_nxt = '0;
          hold_nxt  = '0;
          en_nxt    = 1'b0;
        end
      endcase
    end
  end

`ifdef LED_FADE_GAMMA_EN
  assign w_nxt = gamma(level_nxt);
`else
  assign w_nxt = level_nxt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      level       <= '0;
      hold_cnt    <= '0;
      dim_en      <= 1'b0;
      dim_w       <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      cfg_div     <= '0;
      cfg_hold_hi <= '0;
      cfg_hold_lo <= '0;
      cfg_max     <= '0;
      cfg_loop    <= 1'b0;
    end else begin
      state    <= state_nxt;
      level    <= level_nxt;
      hold_cnt <= hold_nxt;
      dim_en   <= en_nxt;
      dim_w    <= w_nxt;
      busy     <= (state_nxt != IDLE);
      done     <= done_nxt;
      if (cap) begin
        cfg_div     <= step_div;
        cfg_hold_hi <= hold_hi;
        cfg_hold_lo <= hold_lo;
        cfg_max     <= max_level;
        cfg_loop    <= loop;
      end
    end
  end

endmodule

// File: tb/tb_led_fade_ctrl.sv
// Bench for led_fade_ctrl: per-cycle duty/flag checks against a period-list fade model.
module tb_led_fade_ctrl;
  localparam int DIV_W  = 8;
  localparam int HOLD_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              stop = 1'b0;
  logic              loop = 1'b0;
  logic [DIV_W-1:0]  step_div = '0;
  logic [HOLD_W-1:0] hold_hi = '0;
  logic [HOLD_W-1:0] hold_lo = '0;
  logic [3:0]        max_level = '0;
  logic              dim_en, busy, done;
  logic [3:0]        dim_w;

  int total = 0;
  int bad   = 0;

  led_fade_ctrl #(.DIV_W(DIV_W), .HOLD_W(HOLD_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .step_div  (step_div),
    .hold_hi   (hold_hi),
    .hold_lo   (hold_lo),
    .max_level (max_level),
    .loop      (loop),
    .dim_en    (dim_en),
    .dim_w     (dim_w),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] duty(input int lvl);
    int g[16];
`ifdef LED_FADE_GAMMA_EN
    g = '{0, 1, 1, 1, 2, 2, 3, 3, 4, 5, 6, 7, 9, 11, 13, 15};
    return 4'(g[lvl]);
`else
    g[0] = 0;
    return 4'(lvl + g[0]);
`endif
  endfunction

  task automatic scramble_cfg();
    step_div  = DIV_W'($urandom);
    hold_hi   = HOLD_W'($urandom);
    hold_lo   = HOLD_W'($urandom);
    max_level = 4'($urandom);
    loop      = 1'($urandom);
  endtask

  // Model: a fade is a list of per-period levels; each period is (sd+1)*16 cycles,
  // except the very first, which begins at the start edge and is one cycle short.
  task automatic run_fade(input string name, input int sd, input int mx, input int hh,
                          input int hl, input int lp, input int iters,
                          input int stop_at, input int dup_at);
    int per[$];
    int q[$];
    logic [6:0] exp_v, obs_v;
    for (int it = 0; it < iters; it++) begin
      for (int l = 0; l <= mx; l++) per.push_back(l);
      repeat (hh + 1) per.push_back(mx);
      for (int l = mx; l >= 0; l--) per.push_back(l);
      repeat (hl + 1) per.push_back(0);
    end
    foreach (per[p]) repeat ((sd + 1) * 16 - ((p == 0) ? 1 : 0)) q.push_back(per[p]);

    @(negedge clk);
    step_div = DIV_W'(sd); max_level = 4'(mx); hold_hi = HOLD_W'(hh);
    hold_lo = HOLD_W'(hl); loop = 1'(lp); start = 1'b1;
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      start = 1'b0;
      if (i == 0) scramble_cfg();
      exp_v = {1'b1, 1'b1, 1'b0, duty(q[i])};
      obs_v = {dim_en, busy, done, dim_w};
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        if (bad <= 12) $display("FAIL %s cyc=%0d {en,busy,done,w} got=%h want=%h", name, i, obs_v, exp_v);
      end
      if (i == stop_at) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        total++;
        if ({dim_en, busy, done, dim_w} !== 7'h00) begin
          bad++;
          $display("FAIL %s_abort got=%h want=00", name, {dim_en, busy, done, dim_w});
        end
        return;
      end
      if (i == dup_at) begin
        scramble_cfg();
        start = 1'b1;
      end
    end
    @(negedge clk);
    start = 1'b0;
    total++;
    if ({dim_en, busy, done, dim_w} !== 7'b0010000) begin
      bad++;
      $display("FAIL %s_done got=%h want=10", name, {dim_en, busy, done, dim_w});
    end
    @(negedge clk);
    total++;
    if ({dim_en, busy, done, dim_w} !== 7'h00) begin
      bad++;
      $display("FAIL %s_idle got=%h want=00", name, {dim_en, busy, done, dim_w});
    end
  endtask

  task automatic test_reset();
    #1;
    total++;
    if ({dim_en, busy, done, dim_w} !== 7'h00) begin
      bad++;
      $display("FAIL reset_hold got=%h want=00", {dim_en, busy, done, dim_w});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({dim_en, busy, done, dim_w} !== 7'h00) begin
      bad++;
      $display("FAIL reset_release got=%h want=00", {dim_en, busy, done, dim_w});
    end
  endtask

  task automatic test_basic();
    run_fade("basic", 0, 3, 0, 0, 0, 1, -1, -1);
  endtask

  task automatic test_full_ramp();
    run_fade("ramp15", 0, 15, 0, 0, 0, 1, -1, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      run_fade("rand", $urandom_range(2, 0), $urandom_range(15, 0), $urandom_range(3, 0),
               $urandom_range(3, 0), 0, 1, -1, -1);
    end
  endtask

  task automatic test_degenerate();
    run_fade("degen", $urandom_range(1, 0), 0, 2, 0, 0, 1, -1, -1);
  endtask

  task automatic test_loop_abort();
    // Third iteration, inside DOWN (UP is 16 periods, HOLD_HI 1, so period 24 is DOWN).
    run_fade("loop", 2, 15, 0, 0, 1, 3, 1631 + 1632 + 24 * 48 + 5, -1);
  endtask

  task automatic test_conflicts();
    @(negedge clk);
    scramble_cfg();
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    total++;
    if ({dim_en, busy, done, dim_w} !== 7'h00) begin
      bad++;
      $display("FAIL start_stop got=%h want=00", {dim_en, busy, done, dim_w});
    end
    repeat (20) @(negedge clk);
    total++;
    if ({dim_en, busy} !== 2'b00) begin
      bad++;
      $display("FAIL start_stop_later got=%b want=00", {dim_en, busy});
    end
    run_fade("dup_start", 1, 4, 1, 1, 0, 1, -1, $urandom_range(400, 40));
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    max_level = 4'd5; step_div = '0; hold_hi = '0; hold_lo = '0; loop = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);
    total++;
    if ({dim_en, busy, dim_w} !== {1'b1, 1'b1, duty(2)}) begin
      bad++;
      $display("FAIL pre_rst got=%h want=%h", {dim_en, busy, dim_w}, {1'b1, 1'b1, duty(2)});
    end
    #2 rst = 1'b1;
    #1;
    total++;
    if ({dim_en, busy, done, dim_w} !== 7'h00) begin
      bad++;
      $display("FAIL rst_mid got=%h want=00", {dim_en, busy, done, dim_w});
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (40) begin
      @(negedge clk);
      total++;
      if ({dim_en, busy, done, dim_w} !== 7'h00) begin
        bad++;
        $display("FAIL rst_after got=%h want=00", {dim_en, busy, done, dim_w});
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_ramp();
    test_random();
    test_degenerate();
    test_conflicts();
    test_loop_abort();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
